alu_iterative: RTL
==================

ALU_ITERATIVE -- requirements
Module: alu_iterative

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width; any even value >= 8.
REQ-002 SHALL have parameter CNT_W, default log2(DATA_W)+1, iteration counter width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports start in 1, request strobe, and abort in 1, cancel in-flight op.
REQ-006 SHALL have port op  in  3  0 MULU, 1 MULS, 2 DIVU, 3 DIVS, 4 MTLO, 5 MTHI, 6-7 reserved.
REQ-007 SHALL have ports data1 and data2  in  DATA_W  multiplicand/dividend and multiplier/divisor.
REQ-008 SHALL have ports busy out 1, unit occupied, and done out 1, one-cycle completion pulse.
REQ-009 SHALL have ports hi and lo  out  DATA_W  architectural HI/LO registers.
REQ-010 SHALL have port status  out  4  {carry, over, sign, zero}, registered with hi/lo.

Function
REQ-011 SHALL implement FSM IDLE -> CALC -> FIX -> IDLE; busy = (state != IDLE).
REQ-012 SHALL sample start only in IDLE; start while busy is ignored, no queueing.
REQ-013 SHALL, on start with op 0-3 (edge k), latch operand magnitudes (signed ops) or raw values, sign flags, op; go to CALC with counter = DATA_W.
REQ-014 SHALL in CALC process one bit per edge (shift-add multiply, restoring divide), decrement counter, go to FIX when counter reaches 0; FIX edge = k+DATA_W+1.
REQ-015 SHALL at FIX edge apply sign fix, write hi/lo/status, go to IDLE; done high exactly the following cycle.
REQ-016 SHALL produce MUL: {hi,lo} = full 2*DATA_W product; MULS negates product when operand signs differ.
REQ-017 SHALL produce DIV: lo = quotient, hi = remainder; DIVS quotient negated when signs differ, remainder takes dividend sign.
REQ-018 SHALL for divisor 0 (DIVU/DIVS): lo = all ones, hi = data1 unmodified, status.over = 1.
REQ-019 SHALL for DIVS of -2^(DATA_W-1) by -1: lo = 0x80..0, hi = 0, over = 0.
REQ-020 SHALL set status: zero = ({hi,lo}==0); sign = MSB of hi (mul) or lo (div); MULU over = (hi!=0); MULS over = (hi != sign-extension of lo); carry = over for mul, carry = (remainder!=0) for div; div over only per REQ-018.
REQ-021 SHALL on start with MTLO/MTHI write lo/hi = data1 at edge k, leave other register and status unchanged, stay IDLE, pulse done next cycle.
REQ-022 SHALL ignore start with reserved op 6-7: no state change, no done.
REQ-023 SHALL on abort go to IDLE next edge, leave hi/lo/status unchanged, suppress done; abort with start in IDLE: abort wins, start dropped.
REQ-024 SHALL accept a new start in the same cycle done is high.

Reset
REQ-025 SHALL on rst_n low, immediately and regardless of clk: state IDLE, hi = lo = 0, status = 0, busy = 0, done = 0, counter and operand registers 0.
REQ-026 SHALL discard any in-flight operation on reset with no done pulse after release.

Configuration
REQ-027 SHALL with macro ALU_ITERATIVE_EARLY_OUT_EN defined: in MUL CALC, when remaining unprocessed multiplier bits are all zero after an iteration, go to FIX next edge (min one CALC edge); results identical to full run.
REQ-028 SHALL with ALU_ITERATIVE_EARLY_OUT_EN undefined: every MUL/DIV takes exactly DATA_W CALC edges; divide latency unaffected by the macro in either case.

Verification (DATA_W = 32)
REQ-029 SHALL cover MULU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, over=carry=1, done 34 cycles after start edge (macro off).
REQ-030 SHALL cover DIVS -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, carry=1; DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, over=1.
REQ-031 SHALL cover MULS 0xFFFFFFFE*3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, sign=1, over=0.
REQ-032 SHALL cover abort on 10th CALC cycle of MULS -> busy low next edge, hi/lo unchanged, no done; start during busy ignored.
REQ-033 SHALL cover MTHI 0x12345678 while IDLE -> hi=0x12345678 next edge, lo unchanged, done one cycle.
REQ-034 SHALL cover MULU 3*1 with macro on -> lo=3, done 3 cycles after start edge; rst_n low mid-CALC -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_iterative.sv
// alu_iterative: bit-serial multiply/divide unit with architectural HI/LO/status registers.
// Optional macro ALU_ITERATIVE_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module alu_iterative #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic [3:0]        status
);
    localparam int W = DATA_W;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [2*W-1:0]   acc_reg;      // mul: running product; div: {remainder, dividend/quotient}
    logic [2*W-1:0]   mcand_reg;
    logic [W-1:0]     mplier_reg;   // shifting multiplier, or divisor held for the whole divide
    logic             is_div_reg, is_signed_reg, neg_q_reg, neg_r_reg;
    logic [W-1:0]     hi_reg, lo_reg;
    logic [3:0]       status_reg;
    logic             done_reg;

    logic             start_calc, start_move, a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic [2*W-1:0]   mul_acc, div_acc, prod;
    logic [W:0]       rem_sh;
    logic [W+1:0]     trial;
    logic [W-1:0]     quo_fix, rem_fix, res_hi, res_lo;
    logic             div0, res_carry, res_over, res_sign, res_zero;

    always_comb begin
        start_calc = (state_reg == IDLE) && start && !abort && !op[2];
        start_move = (state_reg == IDLE) && start && !abort && op[2] && !op[1];
        a_neg      = op[0] && data1[W-1];
        b_neg      = op[0] && data2[W-1];
        a_mag      = a_neg ? -data1 : data1;
        b_mag      = b_neg ? -data2 : data2;
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_acc = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        rem_sh  = {acc_reg[2*W-1:W], acc_reg[W-1]};
        trial   = {1'b0, rem_sh} - {2'b00, mplier_reg};
        div_acc = trial[W+1] ? {rem_sh[W-1:0], acc_reg[W-2:0], 1'b0}
                             : {trial[W-1:0], acc_reg[W-2:0], 1'b1};
    end

    // Sign correction and flag generation applied on the FIX edge.
    always_comb begin
        prod    = neg_q_reg ? -acc_reg : acc_reg;
        div0    = (mplier_reg == '0);
        quo_fix = neg_q_reg ? -acc_reg[W-1:0] : acc_reg[W-1:0];
        rem_fix = neg_r_reg ? -acc_reg[2*W-1:W] : acc_reg[2*W-1:W];
        res_hi    = prod[2*W-1:W];
        res_lo    = prod[W-1:0];
        res_over  = is_signed_reg ? (res_hi != {W{res_lo[W-1]}}) : (res_hi != '0);
        res_carry = res_over;
        res_sign  = res_hi[W-1];
        if (is_div_reg) begin
            res_hi    = rem_fix;
            res_lo    = div0 ? '1 : quo_fix;
            res_over  = div0;
            res_carry = (rem_fix != '0);
            res_sign  = res_lo[W-1];
        end
        res_zero = (res_hi == '0) && (res_lo == '0);
    end

`ifdef ALU_ITERATIVE_EARLY_OUT_EN
    logic mul_last;
    assign mul_last = (mplier_reg[W-1:1] == '0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (start_calc) state_next = CALC;
            CALC: begin
                if (abort)                          state_next = IDLE;
                else if (cnt_reg == CNT_W'(1))      state_next = FIX;
`ifdef ALU_ITERATIVE_EARLY_OUT_EN
                else if (!is_div_reg && mul_last)   state_next = FIX;
`endif
            end
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            is_div_reg    <= 1'b0;
            is_signed_reg <= 1'b0;
            neg_q_reg     <= 1'b0;
            neg_r_reg     <= 1'b0;
            hi_reg        <= '0;
            lo_reg        <= '0;
            status_reg    <= '0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start_calc) begin
                        cnt_reg       <= CNT_W'(W);
                        acc_reg       <= op[1] ? {{W{1'b0}}, a_mag} : '0;
                        mcand_reg     <= {{W{1'b0}}, a_mag};
                        mplier_reg    <= b_mag;
                        is_div_reg    <= op[1];
                        is_signed_reg <= op[0];
                        neg_q_reg     <= a_neg ^ b_neg;
                        neg_r_reg     <= a_neg;
                    end
                    if (start_move) begin
                        if (op[0]) hi_reg <= data1;
                        else       lo_reg <= data1;
                        done_reg <= 1'b1;
                    end
                end
                CALC: if (!abort) begin
                    cnt_reg <= cnt_reg - CNT_W'(1);
                    if (is_div_reg) begin
                        acc_reg <= div_acc;
                    end else begin
                        acc_reg    <= mul_acc;
                        mcand_reg  <= {mcand_reg[2*W-2:0], 1'b0};
                        mplier_reg <= {1'b0, mplier_reg[W-1:1]};
                    end
                end
                FIX: if (!abort) begin
                    hi_reg     <= res_hi;
                    lo_reg     <= res_lo;
                    status_reg <= {res_carry, res_over, res_sign, res_zero};
                    done_reg   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign hi     = hi_reg;
    assign lo     = lo_reg;
    assign status = status_reg;
endmodule
